// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// ID-stage hazard detection for the 5-stage MIPS pipeline. Detects load-use
// hazards and operand dependencies of branches/JR (which resolve in ID). It
// stalls the front end (PC and IF/ID frozen, bubble into the controller
// register) and squashes the fetched instruction on a taken branch once the
// branch operands are valid. A two-state FSM holds the second cycle of a
// branch-after-load stall. Saturating counters record stalled cycles and
// flushes.
//
// Ports
//   Clk             rising-edge clock
//   Rst             asynchronous active-low reset
//   IFID_Rs/Rt      source register fields of the ID instruction
//   ID_UsesRt       ID instruction reads rt
//   ID_IsBranch     ID instruction is a branch compared in ID (reads rs, rt)
//   ID_IsJR         ID instruction is jr (reads rs only)
//   BranchTaken     ID branch/jump resolves taken this cycle
//   IDEX_MemRead    EX-stage instruction is a load
//   IDEX_RegWrite   EX-stage instruction writes a register
//   IDEX_WriteReg   EX-stage destination register
//   EXMEM_MemRead   MEM-stage instruction is a load
//   EXMEM_WriteReg  MEM-stage destination register
//   StatClr         synchronous clear of both counters
//   Hazard          bubble request to the controller register
//   PCWrite         PC update enable
//   IFIDWrite       IF/ID register update enable
//   IFFlush         squash fetched instruction (also controller Branch input)
//   StallCycles     saturating count of stalled cycles
//   FlushCount      saturating count of flushes issued
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_IsBranch,
  input  logic             ID_IsJR,
  input  logic             BranchTaken,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_WriteReg,
  input  logic             EXMEM_MemRead,
  input  logic [4:0]       EXMEM_WriteReg,
  input  logic             StatClr,
  output logic             Hazard,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFFlush,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         left_q, left_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  // ---------------------------------------------------------------------------
  // Operand matches. Register 0 is hardwired to zero and never creates a
  // dependency, so every match is qualified with a non-zero source.
  // ---------------------------------------------------------------------------
  logic rs_nz, rt_nz;
  logic ex_rs, ex_rt, exl_rs, exl_rt, meml_rs, meml_rt;
  logic is_ctl, use_rt;
  logic exl_any, ex_any, meml_any;
  logic need_two, need_stall;

  assign rs_nz   = (IFID_Rs != 5'd0);
  assign rt_nz   = (IFID_Rt != 5'd0);

  assign ex_rs   = IDEX_RegWrite && (IDEX_WriteReg == IFID_Rs) && rs_nz;
  assign ex_rt   = IDEX_RegWrite && (IDEX_WriteReg == IFID_Rt) && rt_nz;
  assign exl_rs  = ex_rs && IDEX_MemRead;
  assign exl_rt  = ex_rt && IDEX_MemRead;
  assign meml_rs = EXMEM_MemRead && (EXMEM_WriteReg == IFID_Rs) && rs_nz;
  assign meml_rt = EXMEM_MemRead && (EXMEM_WriteReg == IFID_Rt) && rt_nz;

  // Branches always compare rs and rt; jr reads only rs; everything else
  // reads rt only when the decoder says so.
  assign is_ctl  = ID_IsBranch || ID_IsJR;
  assign use_rt  = ID_IsBranch ? 1'b1 : (ID_IsJR ? 1'b0 : ID_UsesRt);

  assign exl_any  = exl_rs  || (use_rt && exl_rt);
  assign ex_any   = ex_rs   || (use_rt && ex_rt);
  assign meml_any = meml_rs || (use_rt && meml_rt);

  // A branch behind a load needs the load data, which only exists after MEM:
  // two bubbles. Every other hazard is covered by one bubble.
  assign need_two   = is_ctl && exl_any;
  assign need_stall = exl_any || (is_ctl && (ex_any || meml_any));

  // ---------------------------------------------------------------------------
  // Stall FSM next-state and stall decision
  // ---------------------------------------------------------------------------
  logic stall_raw, stall;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    stall_raw = 1'b0;
    unique case (state_q)
      S_RUN: begin
        stall_raw = need_stall;
        if (need_two) begin
          state_d = S_STALL;
          left_d  = 2'd1;
        end
      end
      S_STALL: begin
        // Inputs are ignored here: the EX-stage load has moved on, but its
        // data is still not available to the branch compare.
        stall_raw = 1'b1;
        left_d    = left_q - 2'd1;
        if (left_q <= 2'd1) begin
          state_d = S_RUN;
        end
      end
    endcase
  end

  // Reset forces the front end to run freely, whatever the FSM holds.
  assign stall     = Rst && stall_raw;
  assign Hazard    = stall;
  assign PCWrite   = !stall;
  assign IFIDWrite = !stall;
  // The branch outcome is not trustworthy while its operands are stalled, so
  // the squash waits for the first non-stalled cycle.
  assign IFFlush   = Rst && !stall && BranchTaken;

  // ---------------------------------------------------------------------------
  // Saturating event counters; clear wins over an increment.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StatClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (IFFlush && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_RUN;
      left_q      <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed bench for hazard_unit. A behavioural model tracks "stall cycles
// still owed" as an integer and derives the required stall count from the
// source-register list of the ID instruction. A compare process checks every
// DUT output against that model on each falling edge; directed sequences add
// hand-computed literal expectations. Counters are built 4 bits wide so that
// saturation is reachable in a few cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [4:0]       ifid_rs, ifid_rt;
  logic             id_uses_rt, id_is_branch, id_is_jr, branch_taken;
  logic             idex_mem_read, idex_reg_write;
  logic [4:0]       idex_write_reg;
  logic             exmem_mem_read;
  logic [4:0]       exmem_write_reg;
  logic             stat_clr;
  logic             hazard, pc_write, ifid_write, if_flush;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .Clk            (clk),
    .Rst            (rst_n),
    .IFID_Rs        (ifid_rs),
    .IFID_Rt        (ifid_rt),
    .ID_UsesRt      (id_uses_rt),
    .ID_IsBranch    (id_is_branch),
    .ID_IsJR        (id_is_jr),
    .BranchTaken    (branch_taken),
    .IDEX_MemRead   (idex_mem_read),
    .IDEX_RegWrite  (idex_reg_write),
    .IDEX_WriteReg  (idex_write_reg),
    .EXMEM_MemRead  (exmem_mem_read),
    .EXMEM_WriteReg (exmem_write_reg),
    .StatClr        (stat_clr),
    .Hazard         (hazard),
    .PCWrite        (pc_write),
    .IFIDWrite      (ifid_write),
    .IFFlush        (if_flush),
    .StallCycles    (stall_cycles),
    .FlushCount     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_owed;        // stall cycles still owed after the current one
  int m_stall_cnt;
  int m_flush_cnt;
  int e_n;           // required stalls computed for the current cycle
  bit e_stall;
  bit e_flush;

  // Required stall count from the source registers of the ID instruction.
  function automatic int req_stalls();
    logic [4:0] src [2];
    int  nsrc;
    int  n;
    bit  ctl, ex, exl, meml;
    n      = 0;
    ctl    = id_is_branch || id_is_jr;
    src[0] = ifid_rs;
    src[1] = ifid_rt;
    if (id_is_branch)  nsrc = 2;
    else if (id_is_jr) nsrc = 1;
    else               nsrc = id_uses_rt ? 2 : 1;
    for (int i = 0; i < nsrc; i++) begin
      if (src[i] != 5'd0) begin
        ex   = idex_reg_write && (idex_write_reg == src[i]);
        exl  = ex && idex_mem_read;
        meml = exmem_mem_read && (exmem_write_reg == src[i]);
        if (ctl && exl && n < 2)          n = 2;
        if (exl && n < 1)                 n = 1;
        if (ctl && (ex || meml) && n < 1) n = 1;
      end
    end
    return n;
  endfunction

  // Compare process: outputs checked on every falling edge.
  always @(negedge clk) begin
    int  n;
    bit  st, fl;
    if (!rst_n) begin
      n  = 0;
      st = 1'b0;
      fl = 1'b0;
    end else begin
      n  = (m_owed > 0) ? 0 : req_stalls();
      st = (m_owed > 0) || (n > 0);
      fl = !st && branch_taken;
    end
    check("cyc_hazard",    int'(hazard),       int'(st));
    check("cyc_pcwrite",   int'(pc_write),     int'(!st));
    check("cyc_ifidwrite", int'(ifid_write),   int'(!st));
    check("cyc_ifflush",   int'(if_flush),     int'(fl));
    check("cyc_stallcnt",  int'(stall_cycles), m_stall_cnt);
    check("cyc_flushcnt",  int'(flush_count),  m_flush_cnt);
    e_n     <= n;
    e_stall <= st;
    e_flush <= fl;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owed      <= 0;
      m_stall_cnt <= 0;
      m_flush_cnt <= 0;
    end else begin
      if (m_owed > 0)   m_owed <= m_owed - 1;
      else if (e_n > 0) m_owed <= e_n - 1;
      if (stat_clr) begin
        m_stall_cnt <= 0;
        m_flush_cnt <= 0;
      end else begin
        if (e_stall && m_stall_cnt < CNT_MAX) m_stall_cnt <= m_stall_cnt + 1;
        if (e_flush && m_flush_cnt < CNT_MAX) m_flush_cnt <= m_flush_cnt + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    ifid_rs         = 5'd0;
    ifid_rt         = 5'd0;
    id_uses_rt      = 1'b0;
    id_is_branch    = 1'b0;
    id_is_jr        = 1'b0;
    branch_taken    = 1'b0;
    idex_mem_read   = 1'b0;
    idex_reg_write  = 1'b0;
    idex_write_reg  = 5'd0;
    exmem_mem_read  = 1'b0;
    exmem_write_reg = 5'd0;
    stat_clr        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    idle_inputs();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    // Hazard-looking inputs under reset must not stall.
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_write_reg = 5'd8; ifid_rs = 5'd8;
    #3;
    check("rst_hazard",  int'(hazard),   0);
    check("rst_pcwrite", int'(pc_write), 1);
    check("rst_ifflush", int'(if_flush), 0);
    check("rst_stallcnt", int'(stall_cycles), 0);
    tick();
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();

    // Load-use: one stalled cycle.
    clear_stats();
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_write_reg = 5'd8; ifid_rs = 5'd8;
    #1;
    check("lu_hazard",  int'(hazard),   1);
    check("lu_pcwrite", int'(pc_write), 0);
    tick();
    idle_inputs();
    #1;
    check("lu_clear",    int'(hazard),       0);
    check("lu_stallcnt", int'(stall_cycles), 1);

    // Branch after load: two stalled cycles, second one with unrelated inputs.
    clear_stats();
    id_is_branch = 1'b1; ifid_rt = 5'd9; ifid_rs = 5'd3;
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_write_reg = 5'd9;
    #1;
    check("bl_c1", int'(hazard), 1);
    tick();
    idle_inputs();
    ifid_rs = 5'd12; id_uses_rt = 1'b1;
    #1;
    check("bl_c2", int'(hazard), 1);
    tick();
    #1;
    check("bl_run",      int'(hazard),       0);
    check("bl_stallcnt", int'(stall_cycles), 2);

    // Taken branch without hazard.
    clear_stats();
    branch_taken = 1'b1; id_is_branch = 1'b1; ifid_rs = 5'd5; ifid_rt = 5'd6;
    #1;
    check("tb_flush",   int'(if_flush), 1);
    check("tb_hazard",  int'(hazard),   0);
    check("tb_pcwrite", int'(pc_write), 1);
    tick();
    idle_inputs();
    #1;
    check("tb_flushcnt", int'(flush_count), 1);

    // Stall versus flush: the stall wins, flush follows once the match clears.
    clear_stats();
    branch_taken = 1'b1; id_is_branch = 1'b1; ifid_rs = 5'd4;
    idex_reg_write = 1'b1; idex_write_reg = 5'd4;
    #1;
    check("sf_c1_hazard", int'(hazard),   1);
    check("sf_c1_flush",  int'(if_flush), 0);
    tick();
    idex_reg_write = 1'b0;
    #1;
    check("sf_c2_flush",  int'(if_flush), 1);
    check("sf_c2_hazard", int'(hazard),   0);
    tick();
    idle_inputs();

    // $zero destination never stalls, even for a branch behind a load.
    idex_write_reg = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; id_is_branch = 1'b1;
    exmem_mem_read = 1'b1; exmem_write_reg = 5'd0;
    #1;
    check("zero_hazard", int'(hazard), 0);
    tick();
    idle_inputs();

    // jr ignores rt; a normal instruction ignores rt unless ID_UsesRt.
    id_is_jr = 1'b1; ifid_rt = 5'd7; ifid_rs = 5'd1;
    idex_reg_write = 1'b1; idex_write_reg = 5'd7;
    #1;
    check("jr_rt_ignored", int'(hazard), 0);
    tick();
    id_is_jr = 1'b0; idex_mem_read = 1'b1;
    #1;
    check("rt_unused", int'(hazard), 0);
    id_uses_rt = 1'b1;
    #1;
    check("rt_used", int'(hazard), 1);
    tick();
    idle_inputs();

    // Branch behind a load in MEM: one stall.
    id_is_branch = 1'b1; ifid_rs = 5'd10; exmem_mem_read = 1'b1; exmem_write_reg = 5'd10;
    #1;
    check("meml_c1", int'(hazard), 1);
    tick();
    exmem_mem_read = 1'b0;
    #1;
    check("meml_c2", int'(hazard), 0);
    tick();
    idle_inputs();

    // Saturation: a held load-use stalls every cycle; counter pins at max.
    clear_stats();
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_write_reg = 5'd2; ifid_rs = 5'd2;
    repeat (CNT_MAX + 5) tick();
    check("sat_stallcnt", int'(stall_cycles), CNT_MAX);
    // Clear takes precedence over an increment in the same cycle.
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    check("clr_prio", int'(stall_cycles), 0);
    idle_inputs();
    tick();

    // Pseudo-random traffic over a small register set, checked by the model.
    for (int i = 0; i < 300; i++) begin
      ifid_rs         = 5'($urandom_range(0, 3));
      ifid_rt         = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_is_branch    = ($urandom_range(0, 3) == 0);
      id_is_jr        = !id_is_branch && ($urandom_range(0, 5) == 0);
      branch_taken    = 1'($urandom_range(0, 1));
      idex_mem_read   = 1'($urandom_range(0, 1));
      idex_reg_write  = 1'($urandom_range(0, 1));
      idex_write_reg  = 5'($urandom_range(0, 3));
      exmem_mem_read  = 1'($urandom_range(0, 1));
      exmem_write_reg = 5'($urandom_range(0, 3));
      stat_clr        = ($urandom_range(0, 40) == 0);
      tick();
    end
    idle_inputs();
    tick();

    // Reset in the second cycle of a branch-after-load stall.
    id_is_branch = 1'b1; ifid_rs = 5'd9;
    idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_write_reg = 5'd9;
    tick();
    idle_inputs();
    #1;
    check("rms_in_stall", int'(hazard), 1);
    rst_n = 1'b0;
    #1;
    check("rms_hazard",   int'(hazard),       0);
    check("rms_pcwrite",  int'(pc_write),     1);
    check("rms_stallcnt", int'(stall_cycles), 0);
    check("rms_flushcnt", int'(flush_count),  0);
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    check("rms_run_after", int'(hazard), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
